// File: rtl/sync_ram_block.sv
// ----------------------------------------------------------------------------
// sync_ram_block
//
// Purpose:
//   Memory of DEPTH_P words by WIDTH_P bits, with one write port and two
//   independent read ports (A and B). Both read ports are registered and
//   have exactly one cycle of latency. If a read and a write hit the same
//   address on the same edge, the read returns the old (pre-write) word.
//   The storage array has no reset, so a tool can map it onto block RAM.
//   Only the read-data registers are cleared, asynchronously, by rstn_i.
//
// Parameters:
//   WIDTH_P      data word width in bits (>= 1)
//   DEPTH_P      number of words (>= 2); AW = $clog2(DEPTH_P)
//
// Ports:
//   clk_i        in   1        clock, rising edge
//   rstn_i       in   1        asynchronous active-low reset
//   data_i       in   WIDTH_P  write data
//   wr_addr_i    in   AW       write address
//   rd_addr_a_i  in   AW       read address, port A
//   rd_addr_b_i  in   AW       read address, port B
//   wr_en_i      in   1        write enable
//   rd_en_a_i    in   1        read enable, port A
//   rd_en_b_i    in   1        read enable, port B
//   data_a_o     out  WIDTH_P  registered read data, port A
//   data_b_o     out  WIDTH_P  registered read data, port B
//
// Configuration macro:
//   SYNC_RAM_BLOCK_ASSERT_EN  when defined, compiles simulation assertions.
//                             They flag X/Z on the enables and any enabled
//                             access to an address >= DEPTH_P.
// ----------------------------------------------------------------------------
module sync_ram_block #(
    parameter int WIDTH_P = 8,
    parameter int DEPTH_P = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [WIDTH_P-1:0]         data_i,
    input  logic [$clog2(DEPTH_P)-1:0] wr_addr_i,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_a_i,
    input  logic [$clog2(DEPTH_P)-1:0] rd_addr_b_i,
    input  logic                       wr_en_i,
    input  logic                       rd_en_a_i,
    input  logic                       rd_en_b_i,
    output logic [WIDTH_P-1:0]         data_a_o,
    output logic [WIDTH_P-1:0]         data_b_o
);

    localparam int AW = $clog2(DEPTH_P);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];

    logic [WIDTH_P-1:0] data_a_q, data_a_d;
    logic [WIDTH_P-1:0] data_b_q, data_b_d;

    // Address range checks. They only matter when DEPTH_P is not a power of
    // two, because then an AW-bit address can point past the last word.
    logic wr_ok, rd_a_ok, rd_b_ok;

    assign wr_ok   = int'(wr_addr_i)   < DEPTH_P;
    assign rd_a_ok = int'(rd_addr_a_i) < DEPTH_P;
    assign rd_b_ok = int'(rd_addr_b_i) < DEPTH_P;

    // NOTE: the storage array is deliberately left out of any reset.
    // A reset on every word would stop it mapping onto block RAM.
    // Qualifying the write with rstn_i drops a write that lands on an edge
    // while reset is asserted. Words that are already stored are untouched.
    // NOTE: sequential state uses non-blocking assignments, so a read on
    // the same edge sees the pre-write word (old-data read-during-write).
    always_ff @(posedge clk_i) begin
        if (wr_en_i && rstn_i && wr_ok) begin
            mem_q[wr_addr_i] <= data_i;
        end
    end

    // Next read data. An enabled read loads the addressed word, or zero for
    // an address past the end. A disabled read holds the current value.
    // NOTE: each target gets its default value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (rd_en_a_i) begin
            data_a_d = rd_a_ok ? mem_q[rd_addr_a_i] : '0;
        end
        if (rd_en_b_i) begin
            data_b_d = rd_b_ok ? mem_q[rd_addr_b_i] : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

`ifdef SYNC_RAM_BLOCK_ASSERT_EN
    enables_known_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !$isunknown({wr_en_i, rd_en_a_i, rd_en_b_i}))
        else $error("sync_ram_block: X/Z on a read or write enable");

    wr_addr_range_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        wr_en_i |-> wr_ok)
        else $error("sync_ram_block: write address %0d >= DEPTH_P", wr_addr_i);

    rd_a_addr_range_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rd_en_a_i |-> rd_a_ok)
        else $error("sync_ram_block: port A read address %0d >= DEPTH_P", rd_addr_a_i);

    rd_b_addr_range_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
        rd_en_b_i |-> rd_b_ok)
        else $error("sync_ram_block: port B read address %0d >= DEPTH_P", rd_addr_b_i);
`else
    // No checking logic in this build.
`endif

endmodule

// File: tb/tb_sync_ram_block.sv
// ----------------------------------------------------------------------------
// tb_sync_ram_block
//
// Directed testbench for sync_ram_block.
// Two instances share every input:
//   dut   power-of-two depth (16)
//   dut2  non-power-of-two depth (12), used for addresses past the end
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, after the edge has settled.
// ----------------------------------------------------------------------------
module tb_sync_ram_block;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int D2 = 12;
    localparam int AW = 4;

    logic          clk;
    logic          rstn;
    logic [W-1:0]  data;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          wr_en;
    logic          rd_en_a;
    logic          rd_en_b;
    logic [W-1:0]  data_a;
    logic [W-1:0]  data_b;
    logic [W-1:0]  data_a2;
    logic [W-1:0]  data_b2;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] pat [D];

    sync_ram_block #(.WIDTH_P(W), .DEPTH_P(D)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .data_i      (data),
        .wr_addr_i   (wr_addr),
        .rd_addr_a_i (rd_addr_a),
        .rd_addr_b_i (rd_addr_b),
        .wr_en_i     (wr_en),
        .rd_en_a_i   (rd_en_a),
        .rd_en_b_i   (rd_en_b),
        .data_a_o    (data_a),
        .data_b_o    (data_b)
    );

    sync_ram_block #(.WIDTH_P(W), .DEPTH_P(D2)) dut2 (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .data_i      (data),
        .wr_addr_i   (wr_addr),
        .rd_addr_a_i (rd_addr_a),
        .rd_addr_b_i (rd_addr_b),
        .wr_en_i     (wr_en),
        .rd_en_a_i   (rd_en_a),
        .rd_en_b_i   (rd_en_b),
        .data_a_o    (data_a2),
        .data_b_o    (data_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step past the next rising edge and let it settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    // Write one word over a single edge, then return the inputs to idle.
    task automatic write_word(input logic [AW-1:0] addr, input logic [W-1:0] val);
        idle();
        wr_en   = 1'b1;
        wr_addr = addr;
        data    = val;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        data      = '0;
        wr_addr   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle();
        #3;
        checks++;
        if (data_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_a: got %0h expected 0", data_a);
        end
        checks++;
        if (data_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_b: got %0h expected 0", data_b);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        checks++;
        if (data_a !== 8'h00 || data_b !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_idle: got a=%0h b=%0h expected 0/0", data_a, data_b);
        end
    endtask

    task automatic test_basic();
        write_word(4'd0, 8'd42);
        rd_en_a   = 1'b1;
        rd_addr_a = 4'd0;
        tick();
        checks++;
        if (data_a !== 8'd42) begin
            errors++;
            $display("FAIL basic_read_a: got %0d expected 42", data_a);
        end
        idle();
        rd_en_b   = 1'b1;
        rd_addr_b = 4'd0;
        tick();
        checks++;
        if (data_b !== 8'd42) begin
            errors++;
            $display("FAIL basic_read_b: got %0d expected 42", data_b);
        end
        idle();
    endtask

    task automatic test_top_addr();
        write_word(4'(D-1), 8'hFF);
        rd_en_a   = 1'b1;
        rd_en_b   = 1'b1;
        rd_addr_a = 4'(D-1);
        rd_addr_b = 4'(D-1);
        tick();
        checks++;
        if (data_a !== 8'hFF || data_b !== 8'hFF) begin
            errors++;
            $display("FAIL top_addr_dual: got a=%0h b=%0h expected ff/ff", data_a, data_b);
        end
        idle();
    endtask

    task automatic test_read_during_write();
        write_word(4'd0, 8'd7);
        wr_en     = 1'b1;
        wr_addr   = 4'd0;
        data      = 8'd13;
        rd_en_a   = 1'b1;
        rd_addr_a = 4'd0;
        tick();
        checks++;
        if (data_a !== 8'd7) begin
            errors++;
            $display("FAIL rdw_old_data: got %0d expected 7", data_a);
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (data_a !== 8'd13) begin
            errors++;
            $display("FAIL rdw_new_data: got %0d expected 13", data_a);
        end
        idle();
    endtask

    task automatic test_dual_read();
        write_word(4'd0, 8'd55);
        write_word(4'd1, 8'd11);
        rd_en_a   = 1'b1;
        rd_en_b   = 1'b1;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd1;
        tick();
        checks++;
        if (data_a !== 8'd55 || data_b !== 8'd11) begin
            errors++;
            $display("FAIL dual_diff_addr: got a=%0d b=%0d expected 55/11", data_a, data_b);
        end
        write_word(4'd4, 8'd77);
        rd_en_a   = 1'b1;
        rd_en_b   = 1'b1;
        rd_addr_a = 4'd4;
        rd_addr_b = 4'd4;
        tick();
        checks++;
        if (data_a !== 8'd77 || data_b !== 8'd77) begin
            errors++;
            $display("FAIL dual_same_addr: got a=%0d b=%0d expected 77/77", data_a, data_b);
        end
        idle();
    endtask

    task automatic test_hold();
        // Both outputs hold 77. Change the addresses and memory with reads off.
        wr_en     = 1'b1;
        wr_addr   = 4'd4;
        data      = 8'd3;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd1;
        tick();
        idle();
        checks++;
        if (data_a !== 8'd77 || data_b !== 8'd77) begin
            errors++;
            $display("FAIL hold_both: got a=%0d b=%0d expected 77/77", data_a, data_b);
        end
        // Port A alone reads; port B stays put.
        rd_en_a = 1'b1;
        tick();
        idle();
        checks++;
        if (data_a !== 8'd55 || data_b !== 8'd77) begin
            errors++;
            $display("FAIL hold_independent: got a=%0d b=%0d expected 55/77", data_a, data_b);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            pat[i] = 8'((i * 37) + 5);
            write_word(4'(i), pat[i]);
        end
        for (int i = 0; i < D; i++) begin
            idle();
            if (i % 2 == 0) begin
                rd_en_a   = 1'b1;
                rd_addr_a = 4'(i);
            end else begin
                rd_en_b   = 1'b1;
                rd_addr_b = 4'(i);
            end
            tick();
            checks++;
            if (i % 2 == 0) begin
                if (data_a !== pat[i]) begin
                    errors++;
                    $display("FAIL fill_read_a[%0d]: got %0h expected %0h", i, data_a, pat[i]);
                end
            end else begin
                if (data_b !== pat[i]) begin
                    errors++;
                    $display("FAIL fill_read_b[%0d]: got %0h expected %0h", i, data_b, pat[i]);
                end
            end
        end
        idle();
    endtask

    task automatic test_out_of_range();
        // Address 12 is past the end of dut2 but valid in dut.
        write_word(4'd11, 8'h5A);
        write_word(4'd12, 8'hC3);
        rd_en_b   = 1'b1;
        rd_addr_b = 4'd11;
        tick();
        checks++;
        if (data_b2 !== 8'h5A) begin
            errors++;
            $display("FAIL oor_last_valid: got %0h expected 5a", data_b2);
        end
        rd_addr_b = 4'd12;
        tick();
        checks++;
        if (data_b2 !== 8'h00) begin
            errors++;
            $display("FAIL oor_read_zero: got %0h expected 0", data_b2);
        end
        checks++;
        if (data_b !== 8'hC3) begin
            errors++;
            $display("FAIL oor_pow2_valid: got %0h expected c3", data_b);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rd_en_a   = 1'b1;
        rd_en_b   = 1'b1;
        rd_addr_a = 4'd2;
        rd_addr_b = 4'd3;
        tick();
        checks++;
        if (data_a !== pat[2] || data_b !== pat[3]) begin
            errors++;
            $display("FAIL pre_reset_read: got a=%0h b=%0h expected %0h/%0h",
                     data_a, data_b, pat[2], pat[3]);
        end
        // Mid-cycle: outputs must clear without any clock edge.
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (data_a !== 8'h00 || data_b !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_clear: got a=%0h b=%0h expected 0/0", data_a, data_b);
        end
        // A write attempted on an edge while reset is held must be dropped.
        wr_en   = 1'b1;
        wr_addr = 4'd2;
        data    = 8'hEE;
        tick();
        checks++;
        if (data_a !== 8'h00 || data_b !== 8'h00) begin
            errors++;
            $display("FAIL reset_held_outputs: got a=%0h b=%0h expected 0/0", data_a, data_b);
        end
        wr_en = 1'b0;
        rstn  = 1'b1;
        tick();
        checks++;
        if (data_a !== pat[2] || data_b !== pat[3]) begin
            errors++;
            $display("FAIL mem_retained: got a=%0h b=%0h expected %0h/%0h",
                     data_a, data_b, pat[2], pat[3]);
        end
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_top_addr();
        test_read_during_write();
        test_dual_read();
        test_hold();
        test_fill();
        test_out_of_range();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
